// File: rtl/bmc_soft_pipe_if.sv
// Handshake bundle for bmc_soft_pipe: symbol input side, metric output side and symbol count.
// The in_erase mask exists only when BMC_ERASURE_EN is defined.
interface bmc_soft_pipe_if #(
    parameter int N  = 2,
    parameter int SW = 3,
    parameter int CW = 16
);
    localparam int MW = SW + $clog2(N);

    logic            in_valid;
    logic            in_ready;
    logic [N*SW-1:0] rx_soft;
`ifdef BMC_ERASURE_EN
    logic [N-1:0]    in_erase;
`endif
    logic            out_valid;
    logic            out_ready;
    logic [MW-1:0]   path_0_bmc;
    logic [MW-1:0]   path_1_bmc;
    logic            path_min;
    logic [CW-1:0]   sym_cnt;

`ifdef BMC_ERASURE_EN
    modport master (
        output in_valid, rx_soft, in_erase, out_ready,
        input  in_ready, out_valid, path_0_bmc, path_1_bmc, path_min, sym_cnt
    );
    modport slave (
        input  in_valid, rx_soft, in_erase, out_ready,
        output in_ready, out_valid, path_0_bmc, path_1_bmc, path_min, sym_cnt
    );
`else
    modport master (
        output in_valid, rx_soft, out_ready,
        input  in_ready, out_valid, path_0_bmc, path_1_bmc, path_min, sym_cnt
    );
    modport slave (
        input  in_valid, rx_soft, out_ready,
        output in_ready, out_valid, path_0_bmc, path_1_bmc, path_min, sym_cnt
    );
`endif
endinterface

// File: rtl/bmc_soft_pipe.sv
// Soft-decision branch metrics of one rate-1/N symbol against two expected codewords (BMC_ERASURE_EN adds erasures).
// Latency 2 cycles, one symbol per cycle; stages are registered and keep their data while out_ready is low.
// in_ready depends only on stage occupancy and out_ready, so backpressure never loops through in_valid.
module bmc_soft_pipe #(
    parameter int           N    = 2,
    parameter int           SW   = 3,
    parameter logic [N-1:0] EXP0 = {N{1'b1}},
    parameter logic [N-1:0] EXP1 = {N{1'b0}},
    parameter int           CW   = 16
) (
    input  logic           clk,
    input  logic           rst,
    bmc_soft_pipe_if.slave bus
);
    localparam int MW = SW + $clog2(N);

    logic [N-1:0][SW-1:0] w_d0, w_d1;
    logic [N-1:0][SW-1:0] r_s1_d0, r_s1_d1;
    logic [N-1:0]         w_era, r_s1_era;
    logic                 r_s1_vld, r_s2_vld;
    logic                 w_s1_ld, w_s2_ld;
    logic [MW-1:0]        w_sum0, w_sum1;
    logic [MW-1:0]        r_p0, r_p1;
    logic                 r_min;
    logic [CW-1:0]        r_cnt;

`ifdef BMC_ERASURE_EN
    assign w_era = bus.in_erase;
`else
    assign w_era = '0;
`endif

    // Distance to an expected '1' is the bitwise complement, i.e. (2^SW-1) - s.
    always_comb begin
        w_d0 = '0;
        w_d1 = '0;
        for (int i = 0; i < N; i++) begin
            w_d0[i] = EXP0[i] ? ~bus.rx_soft[i*SW +: SW] : bus.rx_soft[i*SW +: SW];
            w_d1[i] = EXP1[i] ? ~bus.rx_soft[i*SW +: SW] : bus.rx_soft[i*SW +: SW];
        end
    end

    always_comb begin
        w_sum0 = '0;
        w_sum1 = '0;
        for (int i = 0; i < N; i++) begin
            if (!r_s1_era[i]) begin
                w_sum0 = w_sum0 + MW'(r_s1_d0[i]);
                w_sum1 = w_sum1 + MW'(r_s1_d1[i]);
            end
        end
    end

    assign w_s2_ld = !r_s2_vld || bus.out_ready;
    assign w_s1_ld = !r_s1_vld || w_s2_ld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_d0  <= '0;
            r_s1_d1  <= '0;
            r_s1_era <= '0;
            r_s2_vld <= 1'b0;
            r_p0     <= '0;
            r_p1     <= '0;
            r_min    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_s1_ld) begin
                r_s1_vld <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_d0  <= w_d0;
                    r_s1_d1  <= w_d1;
                    r_s1_era <= w_era;
                end
            end
            if (w_s2_ld) begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_p0  <= w_sum0;
                    r_p1  <= w_sum1;
                    r_min <= (w_sum1 < w_sum0);
                end
            end
            if (r_s2_vld && bus.out_ready) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign bus.in_ready   = w_s1_ld;
    assign bus.out_valid  = r_s2_vld;
    assign bus.path_0_bmc = r_p0;
    assign bus.path_1_bmc = r_p1;
    assign bus.path_min   = r_min;
    assign bus.sym_cnt    = r_cnt;
endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Directed plus randomized bench for bmc_soft_pipe (N=2, SW=3); a second instance with CW=2 shares the stimulus.
// Expected metrics come from a queue-based reference model of the distance/sum rules.
module tb_bmc_soft_pipe;
    localparam logic [1:0] E0 = 2'b11;
    localparam logic [1:0] E1 = 2'b00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bmc_soft_pipe_if #(.N(2), .SW(3), .CW(16)) bi ();
    bmc_soft_pipe_if #(.N(2), .SW(3), .CW(2))  bj ();

    assign bj.in_valid  = bi.in_valid;
    assign bj.rx_soft   = bi.rx_soft;
    assign bj.out_ready = bi.out_ready;
`ifdef BMC_ERASURE_EN
    assign bj.in_erase  = bi.in_erase;
`endif

    bmc_soft_pipe #(.N(2), .SW(3), .CW(16)) dut  (.clk(clk), .rst(rst), .bus(bi.slave));
    bmc_soft_pipe #(.N(2), .SW(3), .CW(2))  dut2 (.clk(clk), .rst(rst), .bus(bj.slave));

    int n_pass = 0;
    int n_chk  = 0;
    int q0[$];
    int q1[$];
    int cnt = 0;
    bit acc, oxf, inr;
    logic [1:0] er_cur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    function automatic int bm(input logic [5:0] s, input logic [1:0] er, input logic [1:0] e);
        int sum = 0;
        for (int i = 0; i < 2; i++) begin
            int v = int'(s[i*3 +: 3]);
            if (!er[i]) sum += e[i] ? (7 - v) : v;
        end
        return sum;
    endfunction

    task automatic drive(input bit v, input logic [5:0] s, input logic [1:0] er, input bit ordy);
        bi.in_valid  = v;
        bi.rx_soft   = s;
        bi.out_ready = ordy;
`ifdef BMC_ERASURE_EN
        bi.in_erase  = er;
        er_cur       = er;
`else
        er_cur       = 2'b00;
`endif
    endtask

    // One clock: observe at the falling edge, update the model, step past the rising edge.
    task automatic cyc();
        @(negedge clk);
        acc = 0;
        oxf = 0;
        inr = bi.in_ready;
        if (!rst) begin
            if (bi.out_valid) begin
                if (q0.size() == 0) begin
                    chk("out_valid_unexpected", 32'(bi.out_valid), 0);
                end else begin
                    chk("path_0_bmc", 32'(bi.path_0_bmc), q0[0]);
                    chk("path_1_bmc", 32'(bi.path_1_bmc), q1[0]);
                    chk("path_min", 32'(bi.path_min), 32'(q1[0] < q0[0]));
                end
                if (bi.out_ready) begin
                    oxf = 1;
                    chk("sym_cnt", 32'(bi.sym_cnt), cnt % 65536);
                    chk("sym_cnt_cw2", 32'(bj.sym_cnt), cnt % 4);
                    if (q0.size() > 0) begin
                        void'(q0.pop_front());
                        void'(q1.pop_front());
                    end
                    cnt++;
                end
            end
            if (bi.in_valid && bi.in_ready) begin
                acc = 1;
                q0.push_back(bm(bi.rx_soft, er_cur, E0));
                q1.push_back(bm(bi.rx_soft, er_cur, E1));
            end
        end
        @(posedge clk);
        if (rst) begin
            q0.delete();
            q1.delete();
            cnt = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        logic [5:0] syms [4];
        logic [1:0] seq [5];
        int sent, k;
        bit saw_low;

        drive(0, 6'd0, 2'b00, 1);
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_out_valid", 32'(bi.out_valid), 0);
        chk("rst_sym_cnt", 32'(bi.sym_cnt), 0);
        chk("rst_in_ready", 32'(bi.in_ready), 1);
        chk("rst_path_0", 32'(bi.path_0_bmc), 0);
        chk("rst_path_1", 32'(bi.path_1_bmc), 0);
        chk("rst_path_min", 32'(bi.path_min), 0);

        // Single symbol {7,7}: two-cycle latency, fixed expected metrics.
        drive(1, {3'd7, 3'd7}, 2'b00, 1);
        cyc();
        drive(0, 6'd0, 2'b00, 1);
        chk("lat_1cyc_out_valid", 32'(bi.out_valid), 0);
        cyc();
        chk("lat_2cyc_out_valid", 32'(bi.out_valid), 1);
        chk("s77_path_0", 32'(bi.path_0_bmc), 0);
        chk("s77_path_1", 32'(bi.path_1_bmc), 14);
        chk("s77_path_min", 32'(bi.path_min), 0);
        cyc();
        chk("s77_sym_cnt", 32'(bi.sym_cnt), 1);

        // Tie case {b1=0, b0=7}.
        drive(1, {3'd0, 3'd7}, 2'b00, 1);
        cyc();
        drive(0, 6'd0, 2'b00, 1);
        cyc();
        chk("tie_path_0", 32'(bi.path_0_bmc), 7);
        chk("tie_path_1", 32'(bi.path_1_bmc), 7);
        chk("tie_path_min", 32'(bi.path_min), 0);
        cyc();

`ifdef BMC_ERASURE_EN
        drive(1, {3'd5, 3'd3}, 2'b01, 1);
        cyc();
        drive(0, 6'd0, 2'b00, 1);
        cyc();
        chk("era_path_0", 32'(bi.path_0_bmc), 2);
        chk("era_path_1", 32'(bi.path_1_bmc), 5);
        chk("era_path_min", 32'(bi.path_min), 0);
        cyc();
`endif

        // Four back-to-back symbols with out_ready low in cycles 3..5.
        do_reset();
        syms[0] = {3'd1, 3'd6};
        syms[1] = {3'd7, 3'd0};
        syms[2] = {3'd2, 3'd2};
        syms[3] = {3'd0, 3'd0};
        sent = 0;
        saw_low = 0;
        for (int c = 1; c <= 14; c++) begin
            drive(sent < 4, syms[sent % 4], 2'b00, !(c >= 3 && c <= 5));
            cyc();
            if (c == 3) chk("stall_in_ready_low", 32'(inr), 0);
            if (!inr) saw_low = 1;
            if (acc) sent++;
        end
        chk("stall_all_sent", sent, 4);
        chk("stall_saw_backpressure", 32'(saw_low), 1);
        chk("stall_sym_cnt", 32'(bi.sym_cnt), 4);
        chk("stall_queue_empty", q0.size(), 0);

        // Reset with two symbols in flight and a valid input during the reset edge.
        drive(1, {3'd3, 3'd4}, 2'b00, 0);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive(0, 6'd0, 2'b00, 1);
        chk("midrst_out_valid", 32'(bi.out_valid), 0);
        chk("midrst_sym_cnt", 32'(bi.sym_cnt), 0);
        chk("midrst_in_ready", 32'(bi.in_ready), 1);
        cyc();
        cyc();
        chk("midrst_no_output", 32'(bi.out_valid), 0);

        // CW=2 wrap: five transfers give 1,2,3,0,1.
        seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            drive(c < 5, 6'(c * 9), 2'b00, 1);
            cyc();
            if (oxf && k < 5) begin
                chk("wrap_cw2", 32'(bj.sym_cnt), 32'(seq[k]));
                k++;
            end
        end
        chk("wrap_count", k, 5);

        // Random traffic; invalid cycles still carry random data.
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, 6'($urandom), 2'($urandom), $urandom_range(0, 9) < 7);
            cyc();
        end
        drive(0, 6'($urandom), 2'b00, 1);
        for (int c = 0; c < 50 && q0.size() > 0; c++) cyc();
        cyc();
        chk("drain_queue_empty", q0.size(), 0);
        chk("drain_out_valid", 32'(bi.out_valid), 0);
        chk("final_sym_cnt", 32'(bi.sym_cnt), cnt % 65536);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
